// File: rtl/sd_read_arbiter.sv
// sd_read_arbiter
// ---------------
// Front-end scheduler for the SD card controller. After reset it runs the
// card initialisation handshake once. It then shares the controller's
// single-block read port among NUM_REQ requesters in round-robin order,
// drives the read_start/read_done four-phase handshake, captures each
// response, and aborts a read that takes longer than TIMEOUT_CYCLES.
//
// Ports
//   clk, reset_n          clock (shared with the SD controller), async active-low reset
//   req[i], req_addr[i]   per-requester level request and 32-bit block address
//   rsp_valid[i]          one-cycle completion pulse to the served requester
//   rsp_data, rsp_flags   response of the last completed read (held)
//   rsp_err               1 = the last read timed out
//   init_ok, busy         card initialised / FSM not in IDLE
//   sd_*                  handshake and data to/from the SD controller
module sd_read_arbiter #(
    parameter int NUM_REQ        = 2,
    parameter int TIMEOUT_CYCLES = 4096,
    parameter int CNT_W          = 16
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic [NUM_REQ-1:0]     req,
    input  logic [32*NUM_REQ-1:0]  req_addr,
    output logic [NUM_REQ-1:0]     rsp_valid,
    output logic [31:0]            rsp_data,
    output logic [7:0]             rsp_flags,
    output logic                   rsp_err,
    output logic                   init_ok,
    output logic                   busy,
    output logic                   sd_init_start,
    input  logic                   sd_init_done,
    output logic                   sd_read_start,
    input  logic                   sd_read_done,
    output logic [31:0]            sd_addr,
    input  logic [7:0]             sd_response_flags,
    input  logic [31:0]            sd_response_data
);

    localparam int                PTR_W     = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam logic [PTR_W:0]    NUM_REQ_X = (PTR_W + 1)'(NUM_REQ);
    localparam logic [PTR_W-1:0]  PTR_RST   = PTR_W'(NUM_REQ - 1);
    localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_INIT,
        ST_IDLE,
        ST_READ,
        ST_RELEASE
    } state_t;

    state_t             state_q, state_d;
    logic [PTR_W-1:0]   ptr_q, ptr_d;
    logic [PTR_W-1:0]   gnt_q, gnt_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [31:0]        addr_q, addr_d;
    logic [31:0]        data_q, data_d;
    logic [7:0]         flags_q, flags_d;
    logic               err_q, err_d;
    logic               init_ok_q, init_ok_d;
    logic [NUM_REQ-1:0] rsp_valid_q, rsp_valid_d;

    // Per-requester address slices as an array for indexed selection.
    logic [31:0] addr_slice [NUM_REQ];

    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_slice
            assign addr_slice[gi] = req_addr[32*gi +: 32];
        end
    endgenerate

    // A requester whose completion pulse is out this cycle is not eligible,
    // so a continuously held request cannot be regranted on the pulse cycle.
    logic [NUM_REQ-1:0] eligible;
    assign eligible = req & ~rsp_valid_q;

    // Round-robin search: first eligible requester after ptr, wrapping.
    logic [PTR_W:0]   idx;
    logic             found;
    logic [PTR_W-1:0] pick;

    always_comb begin
        found = 1'b0;
        pick  = ptr_q;
        idx   = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            idx = {1'b0, ptr_q} + (PTR_W + 1)'(k);
            if (idx >= NUM_REQ_X) begin
                idx = idx - NUM_REQ_X;
            end
            if (!found && eligible[idx[PTR_W-1:0]]) begin
                found = 1'b1;
                pick  = idx[PTR_W-1:0];
            end
        end
    end

    // Next-state and register-update logic.
    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        gnt_d       = gnt_q;
        cnt_d       = cnt_q;
        addr_d      = addr_q;
        data_d      = data_q;
        flags_d     = flags_q;
        err_d       = err_q;
        init_ok_d   = init_ok_q;
        rsp_valid_d = '0;

        case (state_q)
            ST_INIT: begin
                if (sd_init_done) begin
                    state_d   = ST_IDLE;
                    init_ok_d = 1'b1;
                end
            end
            ST_IDLE: begin
                if (found) begin
                    addr_d  = addr_slice[pick];
                    gnt_d   = pick;
                    ptr_d   = pick;
                    cnt_d   = '0;
                    state_d = ST_READ;
                end
            end
            ST_READ: begin
                cnt_d = cnt_q + 1'b1;
                // A completion seen on the timeout cycle still counts as good.
                if (sd_read_done) begin
                    data_d  = sd_response_data;
                    flags_d = sd_response_flags;
                    err_d   = 1'b0;
                    state_d = ST_RELEASE;
                end else if (cnt_q == CNT_LAST) begin
                    err_d   = 1'b1;
                    state_d = ST_RELEASE;
                end
            end
            ST_RELEASE: begin
                if (!sd_read_done) begin
                    state_d            = ST_IDLE;
                    rsp_valid_d[gnt_q] = 1'b1;
                end
            end
            default: begin
                state_d = ST_INIT;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_INIT;
            ptr_q       <= PTR_RST;
            gnt_q       <= '0;
            cnt_q       <= '0;
            addr_q      <= '0;
            data_q      <= '0;
            flags_q     <= '0;
            err_q       <= 1'b0;
            init_ok_q   <= 1'b0;
            rsp_valid_q <= '0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            gnt_q       <= gnt_d;
            cnt_q       <= cnt_d;
            addr_q      <= addr_d;
            data_q      <= data_d;
            flags_q     <= flags_d;
            err_q       <= err_d;
            init_ok_q   <= init_ok_d;
            rsp_valid_q <= rsp_valid_d;
        end
    end

    // Init request is held off while reset is asserted even though the
    // state register already sits in INIT.
    assign sd_init_start = reset_n & (state_q == ST_INIT);
    assign sd_read_start = (state_q == ST_READ);
    assign busy          = (state_q != ST_IDLE);
    assign sd_addr       = addr_q;
    assign rsp_valid     = rsp_valid_q;
    assign rsp_data      = data_q;
    assign rsp_flags     = flags_q;
    assign rsp_err       = err_q;
    assign init_ok       = init_ok_q;

endmodule

// File: tb/tb_sd_read_arbiter.sv
// Testbench for sd_read_arbiter: models the SD controller, drives random
// requesters, predicts each grant with a round-robin model and checks
// responses through a scoreboard queue popped by an independent monitor.
module tb_sd_read_arbiter;

    localparam int N = 3;
    localparam int T = 24;

    logic            clk = 1'b0;
    logic            reset_n;
    logic [N-1:0]    req;
    logic [32*N-1:0] req_addr;
    logic [N-1:0]    rsp_valid;
    logic [31:0]     rsp_data;
    logic [7:0]      rsp_flags;
    logic            rsp_err, init_ok, busy, sd_init_start, sd_init_done;
    logic            sd_read_start, sd_read_done;
    logic [31:0]     sd_addr, sd_response_data;
    logic [7:0]      sd_response_flags;

    always #5 clk = ~clk;

    sd_read_arbiter #(.NUM_REQ(N), .TIMEOUT_CYCLES(T), .CNT_W(8)) dut (
        .clk(clk), .reset_n(reset_n), .req(req), .req_addr(req_addr),
        .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_flags(rsp_flags),
        .rsp_err(rsp_err), .init_ok(init_ok), .busy(busy),
        .sd_init_start(sd_init_start), .sd_init_done(sd_init_done),
        .sd_read_start(sd_read_start), .sd_read_done(sd_read_done),
        .sd_addr(sd_addr), .sd_response_flags(sd_response_flags),
        .sd_response_data(sd_response_data)
    );

    int checks   = 0;
    int failures = 0;

    typedef struct {
        int          g;
        logic        err;
        logic [31:0] data;
        logic [7:0]  flags;
    } exp_t;

    exp_t exp_q[$];

    // Reference model state.
    int          m_ptr;
    logic [31:0] m_data;
    logic [7:0]  m_flags;
    int          cur_g;
    bit          stop;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
        checks++;
        if (act !== expv) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, expv, $time);
        end
    endtask

    // Eligibility and addresses as the DUT will sample them at the next edge.
    logic [N-1:0] snap_elig;
    logic [31:0]  snap_addr [N];

    initial begin
        snap_elig = '0;
        forever begin
            @(negedge clk);
            #2;
            snap_elig = req & ~rsp_valid;
            for (int i = 0; i < N; i++) snap_addr[i] = req_addr[32*i +: 32];
        end
    end

    // Response monitor: pops the scoreboard whenever a completion pulse shows.
    logic [31:0] mon_data;
    logic [7:0]  mon_flags;
    logic        mon_err;
    logic [N-1:0] prev_rv;
    exp_t        mon_e;
    logic [N-1:0] mon_oh;

    initial begin
        mon_data = '0; mon_flags = '0; mon_err = 1'b0; prev_rv = '0;
        forever begin
            @(negedge clk);
            if (!reset_n) begin
                mon_data = '0; mon_flags = '0; mon_err = 1'b0; prev_rv = '0;
            end else begin
                if (prev_rv != '0) check("rsp_pulse_width", rsp_valid, 0);
                prev_rv = rsp_valid;
                if (rsp_valid != '0) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL unexpected_rsp: got rsp_valid 0x%0h expected none at %0t", rsp_valid, $time);
                    end else begin
                        mon_e = exp_q.pop_front();
                        mon_oh = '0;
                        mon_oh[mon_e.g] = 1'b1;
                        check("rsp_valid", rsp_valid, mon_oh);
                        check("rsp_err", rsp_err, mon_e.err);
                        check("rsp_data", rsp_data, mon_e.data);
                        check("rsp_flags", rsp_flags, mon_e.flags);
                        mon_data = mon_e.data; mon_flags = mon_e.flags; mon_err = mon_e.err;
                    end
                end else if (!busy) begin
                    check("hold_data", rsp_data, mon_data);
                    check("hold_flags", rsp_flags, mon_flags);
                    check("hold_err", rsp_err, mon_err);
                end
            end
        end
    end

    // Initialisation handshake: n cycles of init_done=0, then one cycle of 1.
    task automatic do_init(input int n);
        repeat (n) begin
            @(negedge clk);
            check("init_start", sd_init_start, 1);
            check("init_busy", busy, 1);
            check("init_ok_low", init_ok, 0);
        end
        sd_init_done = 1'b1;
        @(negedge clk);
        sd_init_done = 1'b0;
        check("init_start_drop", sd_init_start, 0);
        check("init_ok_high", init_ok, 1);
        check("idle_busy", busy, 0);
    endtask

    // Controller model for one read: waits for the grant, predicts it,
    // answers after lat cycles (or never, if to), holds done for hold cycles.
    task automatic serve_read(input int lat, input int hold, input bit to,
                              input logic [31:0] d, input logic [7:0] f);
        int          wait_c;
        bit          was_idle;
        int          g;
        int          k;
        logic [31:0] ea;
        exp_t        e;
        wait_c   = 0;
        was_idle = 1'b0;
        g        = -1;
        forever begin
            @(negedge clk);
            if (sd_read_start) break;
            if (was_idle) check("grant_missed", snap_elig, 0);
            was_idle = !busy;
            wait_c++;
            if (wait_c > 100) begin
                checks++;
                failures++;
                $display("FAIL grant_wait: sd_read_start got 0 expected 1 within 100 cycles at %0t", $time);
                return;
            end
        end
        check("grant_had_req", (snap_elig != '0), 1);
        for (int s = 1; s <= N; s++) begin
            int c;
            c = (m_ptr + s) % N;
            if (g < 0 && snap_elig[c]) g = c;
        end
        if (g < 0) g = (m_ptr + 1) % N;
        m_ptr = g;
        cur_g = g;
        ea    = snap_addr[g];
        check("busy_read", busy, 1);
        k = 0;
        forever begin
            check("read_start_hi", sd_read_start, 1);
            check("sd_addr", sd_addr, ea);
            if (!to && k == lat) begin
                sd_read_done      = 1'b1;
                sd_response_data  = d;
                sd_response_flags = f;
                e = '{g: g, err: 1'b0, data: d, flags: f};
                m_data  = d;
                m_flags = f;
                exp_q.push_back(e);
                break;
            end
            if (to && k == T - 1) begin
                e = '{g: g, err: 1'b1, data: m_data, flags: m_flags};
                exp_q.push_back(e);
                break;
            end
            sd_response_data  = $urandom;
            sd_response_flags = 8'($urandom);
            @(negedge clk);
            k++;
        end
        @(negedge clk);
        check("read_start_len", sd_read_start, 0);
        if (to) hold = 0;
        repeat (hold) begin
            check("rsp_wait_done", rsp_valid, 0);
            check("sd_addr_release", sd_addr, ea);
            sd_response_data  = $urandom;
            sd_response_flags = 8'($urandom);
            @(negedge clk);
        end
        sd_read_done     = 1'b0;
        sd_response_data = $urandom;
        @(negedge clk);
        check("rsp_latency", (rsp_valid != '0), 1);
        cur_g = -1;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit found;
        reset_n = 1'b0; req = '0; req_addr = '0; sd_init_done = 1'b0;
        sd_read_done = 1'b0; sd_response_data = '0; sd_response_flags = '0;
        stop = 1'b0; cur_g = -1; m_ptr = N - 1; m_data = '0; m_flags = '0;

        // Reset state.
        repeat (3) @(negedge clk);
        check("rst_init_start", sd_init_start, 0);
        check("rst_init_ok", init_ok, 0);
        check("rst_read_start", sd_read_start, 0);
        check("rst_sd_addr", sd_addr, 0);
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_rsp_data", rsp_data, 0);
        check("rst_rsp_flags", rsp_flags, 0);
        check("rst_rsp_err", rsp_err, 0);
        #1 reset_n = 1'b1;
        do_init(10);

        // Single requester, long latency.
        #1;
        req_addr[31:0] = 32'h0000_0200;
        req = 3'b001;
        serve_read(20, 0, 1'b0, 32'hDEAD_BEEF, 8'h00);
        #1 req = '0;

        // Two requesters held for four reads.
        req_addr[31:0]  = $urandom;
        req_addr[63:32] = $urandom;
        req = 3'b011;
        for (int r = 0; r < 4; r++) begin
            serve_read($urandom_range(0, 10), $urandom_range(0, 3), 1'b0, $urandom, 8'($urandom));
        end
        #1 req = '0;

        // Timeout: data and flags must be kept.
        req_addr[63:32] = $urandom;
        req = 3'b010;
        serve_read(0, 0, 1'b1, 32'h0, 8'h0);
        #1 req = '0;

        // Done on the timeout cycle, then done held after read_start drops.
        req_addr[95:64] = $urandom;
        req = 3'b100;
        serve_read(T - 1, 0, 1'b0, $urandom, 8'($urandom));
        serve_read(3, 5, 1'b0, $urandom, 8'($urandom));
        #1 req = '0;

        // Random phase.
        fork
            begin
                while (!stop) begin
                    @(posedge clk);
                    #1;
                    for (int i = 0; i < N; i++) begin
                        if (req[i] && rsp_valid[i]) begin
                            if ($urandom_range(0, 1) == 0) req[i] = 1'b0;
                            else req_addr[32*i +: 32] = $urandom;
                        end else if (!req[i]) begin
                            if ($urandom_range(0, 3) == 0) begin
                                req[i] = 1'b1;
                                req_addr[32*i +: 32] = $urandom;
                            end
                        end else if (i == cur_g && $urandom_range(0, 15) == 0) begin
                            req[i] = 1'b0;
                        end else if ($urandom_range(0, 7) == 0) begin
                            req_addr[32*i +: 32] = $urandom;
                        end
                    end
                end
            end
            begin
                for (int r = 0; r < 60; r++) begin
                    int  m;
                    bit  to_r;
                    int  lat_r;
                    m     = $urandom_range(0, 9);
                    to_r  = (m < 2);
                    lat_r = (m == 2) ? T - 1 : $urandom_range(0, 10);
                    serve_read(lat_r, $urandom_range(0, 4), to_r, $urandom, 8'($urandom));
                end
                stop = 1'b1;
            end
        join

        // Reset in the middle of a read.
        req = '1;
        found = 1'b0;
        for (int w = 0; w < 50 && !found; w++) begin
            @(negedge clk);
            if (sd_read_start) found = 1'b1;
        end
        check("mid_read_reached", found, 1);
        #2 reset_n = 1'b0;
        m_ptr = N - 1; m_data = '0; m_flags = '0; cur_g = -1;
        req = '0; sd_read_done = 1'b0;
        #1;
        check("mid_rst_read_start", sd_read_start, 0);
        check("mid_rst_rsp_valid", rsp_valid, 0);
        check("mid_rst_init_start", sd_init_start, 0);
        check("mid_rst_init_ok", init_ok, 0);
        check("mid_rst_sd_addr", sd_addr, 0);
        repeat (2) @(negedge clk);
        #1 reset_n = 1'b1;
        do_init(4);

        // First grant after reset goes to requester 0.
        #1;
        for (int i = 0; i < N; i++) req_addr[32*i +: 32] = $urandom;
        req = '1;
        serve_read($urandom_range(0, 6), 0, 1'b0, $urandom, 8'($urandom));
        serve_read($urandom_range(0, 6), 1, 1'b0, $urandom, 8'($urandom));
        #1 req = '0;
        repeat (4) @(negedge clk);
        check("scoreboard_empty", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
